pulse_width_meter: RTL and testbench

- Receive-side companion to the team's astable pulse generator.
- Samples an asynchronous pulse train and measures the high and low time of each full period in clk cycles.
- Reports each measurement with a one-cycle valid strobe, and flags stuck (no-edge) and counter-overflow conditions.
- Sits between the pulse source and the lab checker/display logic, which compares measured on/off durations against expected R/C values.

---
 rtl/pulse_width_meter_if.sv | 24 ++
 rtl/pulse_width_meter.sv | 157 +++++++++++++++
 tb/tb_pulse_width_meter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_width_meter_if.sv
// rtl/pulse_width_meter_if.sv - Control and measurement-result signals of pulse_width_meter
interface pulse_width_meter_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             pulse_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             meas_valid;
    logic             overflow;
    logic             stuck;

    // Source side: drives enable and the pulse train, consumes results.
    modport master (
        output en, pulse_in,
        input  high_cnt, low_cnt, meas_valid, overflow, stuck
    );

    // Meter side.
    modport slave (
        input  en, pulse_in,
        output high_cnt, low_cnt, meas_valid, overflow, stuck
    );
endinterface

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - Measures high/low time of each period of an asynchronous pulse train
module pulse_width_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_width_meter_if.slave    pw
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t           state, state_d;
    logic             s1, s2, s2_d;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [CNT_W-1:0] hi_latch, hi_latch_d;
    logic             ovf_latch, ovf_latch_d;
    logic             stuck_q, stuck_d;
    logic             count_en;
    logic             report;
    logic [CNT_W-1:0] high_q, low_q;
    logic             valid_q, ovf_q;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= pw.pulse_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise    = s2 & ~s2_d;
    assign fall    = ~s2 & s2_d;
    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

    // Next-state and datapath decisions for the measurement FSM.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        hi_latch_d  = hi_latch;
        ovf_latch_d = ovf_latch;
        stuck_d     = stuck_q;
        count_en    = 1'b0;
        report      = 1'b0;

        if (!pw.en) begin
            // Any in-progress period is dropped; results stay as they are.
            state_d = IDLE;
            cnt_d   = '0;
            stuck_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_d   = '0;
                    stuck_d = 1'b0;
                    state_d = WAIT_RISE;
                end
                WAIT_RISE: begin
                    // Counting here only serves the stuck detector.
                    if (rise) begin
                        cnt_d       = 1;
                        ovf_latch_d = 1'b0;
                        stuck_d     = 1'b0;
                        state_d     = MEAS_HIGH;
                    end else begin
                        count_en = 1'b1;
                        if (fall) stuck_d = 1'b0;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        hi_latch_d = cnt;
                        cnt_d      = 1;
                        stuck_d    = 1'b0;
                        state_d    = MEAS_LOW;
                    end else if (s2) begin
                        count_en = 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        report      = 1'b1;
                        cnt_d       = 1;
                        ovf_latch_d = 1'b0;
                        stuck_d     = 1'b0;
                        state_d     = MEAS_HIGH;
                    end else if (!s2) begin
                        count_en = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (count_en) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_MAX) ovf_latch_d = 1'b1;
                if (cnt_inc == CNT_TO)  stuck_d     = 1'b1;
            end
        end
    end

    // State, counter and latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_latch  <= '0;
            ovf_latch <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hi_latch  <= hi_latch_d;
            ovf_latch <= ovf_latch_d;
            stuck_q   <= stuck_d;
        end
    end

    // Result registers: updated only on the rise that completes a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_q  <= '0;
            low_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= report;
            if (report) begin
                high_q <= hi_latch;
                low_q  <= cnt;
                ovf_q  <= ovf_latch | (cnt == CNT_MAX);
            end
        end
    end

    assign pw.high_cnt   = high_q;
    assign pw.low_cnt    = low_q;
    assign pw.meas_valid = valid_q;
    assign pw.overflow   = ovf_q;
    assign pw.stuck      = stuck_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - Self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_width_meter_if #(.CNT_W(16)) ia ();
    pulse_width_meter_if #(.CNT_W(4))  ib ();

    pulse_width_meter #(.CNT_W(16), .TIMEOUT(1000)) dut_a (.clk(clk), .rst(rst), .pw(ia.slave));
    pulse_width_meter #(.CNT_W(4),  .TIMEOUT(12))   dut_b (.clk(clk), .rst(rst), .pw(ib.slave));

    typedef struct {
        int cyc;
        int hi;
        int lo;
        int ovf;
    } rec_t;

    rec_t got_a[$];
    rec_t got_b[$];
    rec_t exp_q[$];

    int   prev_h, prev_l;
    bit   have_prev = 1'b0;
    int   last_a_hi, last_a_lo, last_a_ovf;
    int   last_b_hi, last_b_lo, last_b_ovf;

    // Capture every result strobe of both meters, away from the active edge.
    always @(negedge clk) begin
        rec_t r;
        if (ia.meas_valid === 1'b1) begin
            r.cyc = cyc; r.hi = int'(ia.high_cnt); r.lo = int'(ia.low_cnt); r.ovf = int'(ia.overflow);
            got_a.push_back(r);
        end
        if (ib.meas_valid === 1'b1) begin
            r.cyc = cyc; r.hi = int'(ib.high_cnt); r.lo = int'(ib.low_cnt); r.ovf = int'(ib.overflow);
            got_b.push_back(r);
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pin(logic v);
        ia.pulse_in = v;
        ib.pulse_in = v;
    endtask

    task automatic set_en(logic v);
        ia.en = v;
        ib.en = v;
    endtask

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    // A rise completes the previously driven full period (if any); its result
    // is due three cycles after the cycle the input goes high.
    task automatic edge_rise();
        rec_t e;
        if (have_prev) begin
            e.cyc = cyc + 3; e.hi = prev_h; e.lo = prev_l; e.ovf = 0;
            exp_q.push_back(e);
        end
        set_pin(1'b1);
        have_prev = 1'b0;
    endtask

    task automatic period(int h, int l);
        edge_rise();
        tick(h);
        set_pin(1'b0);
        tick(l);
        prev_h = h; prev_l = l; have_prev = 1'b1;
    endtask

    task automatic close_run();
        edge_rise();
        tick(6);
    endtask

    task automatic end_run();
        set_en(1'b0);
        set_pin(1'b0);
        tick(4);
        set_en(1'b1);
        tick(4);
        have_prev = 1'b0;
    endtask

    // Compare captured strobes of both meters against the expected periods.
    task automatic verify(string name);
        check($sformatf("%s/count_a", name), got_a.size(), exp_q.size());
        check($sformatf("%s/count_b", name), got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_a.size()) begin
                check($sformatf("%s/a_cyc%0d", name, i), got_a[i].cyc, exp_q[i].cyc);
                check($sformatf("%s/a_hi%0d", name, i),  got_a[i].hi,  sat(exp_q[i].hi, 65535));
                check($sformatf("%s/a_lo%0d", name, i),  got_a[i].lo,  sat(exp_q[i].lo, 65535));
                check($sformatf("%s/a_ovf%0d", name, i), got_a[i].ovf,
                      int'(exp_q[i].hi >= 65535 || exp_q[i].lo >= 65535));
            end
            if (i < got_b.size()) begin
                check($sformatf("%s/b_hi%0d", name, i),  got_b[i].hi,  sat(exp_q[i].hi, 15));
                check($sformatf("%s/b_lo%0d", name, i),  got_b[i].lo,  sat(exp_q[i].lo, 15));
                check($sformatf("%s/b_ovf%0d", name, i), got_b[i].ovf,
                      int'(exp_q[i].hi >= 15 || exp_q[i].lo >= 15));
            end
        end
        if (exp_q.size() > 0) begin
            last_a_hi  = sat(exp_q[$].hi, 65535);
            last_a_lo  = sat(exp_q[$].lo, 65535);
            last_a_ovf = int'(exp_q[$].hi >= 65535 || exp_q[$].lo >= 65535);
            last_b_hi  = sat(exp_q[$].hi, 15);
            last_b_lo  = sat(exp_q[$].lo, 15);
            last_b_ovf = int'(exp_q[$].hi >= 15 || exp_q[$].lo >= 15);
        end
        got_a.delete();
        got_b.delete();
        exp_q.delete();
    endtask

    initial begin
        set_en(1'b0);
        set_pin(1'b0);
        tick(3);

        // Reset state.
        check("rst/high_cnt", ia.high_cnt, 0);
        check("rst/low_cnt", ia.low_cnt, 0);
        check("rst/meas_valid", ia.meas_valid, 0);
        check("rst/overflow", ia.overflow, 0);
        check("rst/stuck", ia.stuck, 0);
        check("rst/b_high_cnt", ib.high_cnt, 0);

        rst = 1'b0;
        set_en(1'b1);
        tick(4);

        // Regular 5 high / 3 low train: strobes 8 cycles apart, first after 2nd rise.
        repeat (5) period(5, 3);
        close_run();
        verify("p5x3");
        end_run();

        // Generator-like symmetric 35/35 waveform.
        repeat (2) period(35, 35);
        close_run();
        verify("p35");
        end_run();

        // Long high phase saturates the 4-bit meter; the next period is clean.
        period(20, 3);
        period(5, 3);
        close_run();
        verify("sat");
        end_run();

        // Random durations including the one-cycle boundary.
        for (int i = 0; i < 8; i++) period($urandom_range(1, 40), $urandom_range(1, 40));
        period(1, 1);
        period(1, 2);
        close_run();
        verify("rand");
        end_run();

        // Input stuck low after a measurement.
        period(6, 4);
        edge_rise();
        tick(7);
        set_pin(1'b0);
        tick(990);
        check("stuck/early", ia.stuck, 0);
        tick(30);
        check("stuck/set", ia.stuck, 1);
        check("stuck/b_set", ib.stuck, 1);
        tick(180);
        verify("stuck");
        set_pin(1'b1);
        tick(4);
        check("stuck/clear", ia.stuck, 0);
        end_run();
        got_a.delete();
        got_b.delete();

        // Enable dropped in the low phase: no strobe, results hold.
        period(5, 3);
        period(7, 4);
        edge_rise();
        tick(6);
        set_pin(1'b0);
        tick(5);
        set_en(1'b0);
        tick(6);
        verify("en_drop");
        check("en_drop/hold_hi", ia.high_cnt, last_a_hi);
        check("en_drop/hold_lo", ia.low_cnt, last_a_lo);
        check("en_drop/hold_ovf", ia.overflow, last_a_ovf);
        check("en_drop/stuck", ia.stuck, 0);

        // Reset in the middle of a high phase clears outputs at once.
        set_en(1'b1);
        tick(4);
        edge_rise();
        tick(4);
        rst = 1'b1;
        #2;
        check("async_rst/high_cnt", ia.high_cnt, 0);
        check("async_rst/low_cnt", ia.low_cnt, 0);
        check("async_rst/b_high_cnt", ib.high_cnt, 0);
        set_pin(1'b0);
        tick(3);
        rst = 1'b0;
        tick(4);
        check("after_rst/no_strobe", got_a.size(), 0);

        // A full fresh period is needed before the next strobe.
        have_prev = 1'b0;
        period(9, 6);
        period(4, 2);
        close_run();
        verify("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
